// File: rtl/mem_req_queue.sv
// In-order load/store request queue in front of memInerf: one request in flight,
// a forced low cycle between operations, and a watchdog on the mem_done handshake.
module mem_req_queue #(
   parameter int DEPTH   = 4,
   parameter int ADDR_W  = 14,
   parameter int DATA_W  = 16,
   parameter int RSP_W   = 8,
   parameter int TIMEOUT = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_is_store,
   input  logic [ADDR_W-1:0]      req_addr,
   input  logic [DATA_W-1:0]      req_data,
   output logic                   store,
   output logic                   load,
   output logic [ADDR_W-1:0]      addr,
   output logic [DATA_W-1:0]      result,
   input  logic                   mem_done,
   input  logic [RSP_W-1:0]       datatoinst,
   output logic                   rsp_valid,
   output logic [RSP_W-1:0]       rsp_data,
   output logic                   rsp_err,
   output logic                   busy,
   output logic                   timeout_err,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int TMR_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_e;

   logic              fifo_st_q   [DEPTH];
   logic [ADDR_W-1:0] fifo_addr_q [DEPTH];
   logic [DATA_W-1:0] fifo_data_q [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   state_e            state_q;
   logic [TMR_W-1:0]  timer_q;
   logic              store_q, load_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] result_q;
   logic              rsp_valid_q, rsp_err_q, timeout_err_q;
   logic [RSP_W-1:0]  rsp_data_q;

   logic push, pop, last_cycle;

   // Ready looks only at the registered count, so a same-cycle pop never frees a slot.
   assign req_ready  = !reset && (count_q != CNT_FULL);
   assign push       = req_valid && req_ready;
   assign last_cycle = (timer_q == TMR_LAST);
   assign pop        = (state_q == ISSUE) && (mem_done || last_cycle);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_st_q[wr_ptr_q]   <= req_is_store;
         fifo_addr_q[wr_ptr_q] <= req_addr;
         fifo_data_q[wr_ptr_q] <= req_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         timer_q       <= '0;
         store_q       <= 1'b0;
         load_q        <= 1'b0;
         addr_q        <= '0;
         result_q      <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_err_q     <= 1'b0;
         rsp_data_q    <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               store_q <= 1'b0;
               load_q  <= 1'b0;
               timer_q <= '0;
               if (count_q != '0) begin
                  state_q  <= ISSUE;
                  store_q  <= fifo_st_q[rd_ptr_q];
                  load_q   <= !fifo_st_q[rd_ptr_q];
                  addr_q   <= fifo_addr_q[rd_ptr_q];
                  result_q <= fifo_data_q[rd_ptr_q];
               end
            end
            ISSUE: begin
               timer_q <= timer_q + TMR_W'(1);
               if (pop) begin
                  state_q <= GAP;
                  store_q <= 1'b0;
                  load_q  <= 1'b0;
                  timer_q <= '0;
                  rsp_valid_q <= load_q;
                  // A completion on the final watchdog cycle still counts as a completion.
                  if (mem_done) begin
                     if (load_q) rsp_data_q <= datatoinst;
                  end else begin
                     rsp_err_q     <= load_q;
                     timeout_err_q <= 1'b1;
                  end
               end
            end
            GAP: begin
               state_q <= IDLE;
               timer_q <= '0;
            end
            default: begin
               state_q <= IDLE;
               store_q <= 1'b0;
               load_q  <= 1'b0;
               timer_q <= '0;
            end
         endcase
      end
   end

   assign store       = store_q;
   assign load        = load_q;
   assign addr        = addr_q;
   assign result      = result_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_data    = rsp_data_q;
   assign timeout_err = timeout_err_q;
   assign count       = count_q;
   assign busy        = (count_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_mem_req_queue.sv
// Bench for mem_req_queue: a small SRAM responder, an issue/response scoreboard
// and directed checks for latency, backpressure, timeout and reset.
module tb_mem_req_queue;

   localparam int DEPTH   = 4;
   localparam int ADDR_W  = 14;
   localparam int DATA_W  = 16;
   localparam int RSP_W   = 8;
   localparam int TIMEOUT = 64;

   typedef struct packed {
      logic              st;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } iss_t;

   typedef struct packed {
      logic             err;
      logic [RSP_W-1:0] d;
   } rsp_t;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   req_valid, req_ready, req_is_store;
   logic [ADDR_W-1:0]      req_addr;
   logic [DATA_W-1:0]      req_data;
   logic                   store, load;
   logic [ADDR_W-1:0]      addr;
   logic [DATA_W-1:0]      result;
   logic                   mem_done;
   logic [RSP_W-1:0]       datatoinst;
   logic                   rsp_valid, rsp_err, busy, timeout_err;
   logic [RSP_W-1:0]       rsp_data;
   logic [$clog2(DEPTH):0] count;

   int n_checks = 0;
   int n_fail   = 0;

   iss_t exp_iss[$];
   rsp_t exp_rsp[$];

   int             lat = 3;
   logic           stray = 1'b0;
   int             resp_cyc = 0;
   logic [RSP_W-1:0] model_rsp = '0;
   logic [7:0]     mem [0:(1<<ADDR_W)-1];

   int   held = 0;
   logic in_iss = 1'b0;
   logic exp_terr = 1'b0;
   int   rsp_seen = 0;
   iss_t cur;
   rsp_t e_rsp;

   mem_req_queue #(
      .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RSP_W(RSP_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
      .req_addr(req_addr), .req_data(req_data),
      .store(store), .load(load), .addr(addr), .result(result),
      .mem_done(mem_done), .datatoinst(datatoinst),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .busy(busy), .timeout_err(timeout_err), .count(count)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic push_req(input logic st, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      int n = 0;
      req_valid = 1'b1; req_is_store = st; req_addr = a; req_data = d;
      while (!req_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq("push_ready", 32'(req_ready), 1);
      if (req_ready) exp_iss.push_back({st, a, d});
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_idle(input int max_cyc);
      int n = 0;
      while (busy && n < max_cyc) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq("idle_reached", 32'(busy), 0);
      check_eq("idle_count", 32'(count), 0);
   endtask

   // SRAM responder: mem_done after 'lat' issue cycles (0 = never).
   initial begin
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'h00;
      mem_done = 1'b0;
      datatoinst = '0;
      forever begin
         @(negedge clk); #1;
         if (reset) begin
            resp_cyc = 0;
            mem_done = 1'b0;
            model_rsp = '0;
         end else begin
            mem_done = 1'b0;
            datatoinst = 8'($urandom);
            if (store || load) begin
               resp_cyc++;
               if (lat != 0 && resp_cyc == lat) begin
                  mem_done = 1'b1;
                  if (store) mem[addr] = result[7:0];
                  else begin
                     datatoinst = mem[addr];
                     model_rsp = mem[addr];
                     exp_rsp.push_back({1'b0, mem[addr]});
                  end
               end
            end else begin
               resp_cyc = 0;
               mem_done = stray;
            end
         end
      end
   end

   // Monitor: issue order/stability, issue length, responses.
   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            in_iss = 1'b0;
            held = 0;
            exp_terr = 1'b0;
         end else begin
            if (store || load) begin
               if (!in_iss) begin
                  in_iss = 1'b1;
                  held = 1;
                  check_eq("excl", 32'(store & load), 0);
                  if (exp_iss.size() == 0) check_eq("iss_unexpected", 1, 0);
                  else begin
                     cur = exp_iss.pop_front();
                     check_eq("issue", {store, load, addr, result}, {cur.st, !cur.st, cur.a, cur.d});
                  end
               end else begin
                  held++;
                  check_eq("hold", {store, load, addr, result}, {cur.st, !cur.st, cur.a, cur.d});
               end
            end else if (in_iss) begin
               in_iss = 1'b0;
               if (mem_done) check_eq("iss_len", held, lat);
               else begin
                  check_eq("to_len", held, TIMEOUT);
                  exp_terr = 1'b1;
                  if (!cur.st) exp_rsp.push_back({1'b1, model_rsp});
               end
            end
            if (rsp_valid) begin
               rsp_seen++;
               if (exp_rsp.size() == 0) check_eq("rsp_unexpected", 1, 0);
               else begin
                  e_rsp = exp_rsp.pop_front();
                  check_eq("rsp", 32'({rsp_err, rsp_data}), 32'({e_rsp.err, e_rsp.d}));
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      int seen;
      req_valid = 1'b0; req_is_store = 1'b0; req_addr = '0; req_data = '0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_outs", 32'({store, load, rsp_valid, rsp_err, busy, timeout_err, req_ready}), 0);
      check_eq("rst_count", 32'(count), 0);
      check_eq("rst_bus", 32'({addr, result, rsp_data}), 0);
      reset = 1'b0;
      @(posedge clk); #1;
      check_eq("ready_after_rst", 32'(req_ready), 1);

      // Single store, mem_done 3 cycles after issue
      lat = 3;
      push_req(1'b1, 14'h0123, 16'hBEEF);
      check_eq("count_push", 32'(count), 1);
      check_eq("busy_push", 32'(busy), 1);
      check_eq("pre_issue", 32'(store), 0);
      @(posedge clk); #1;
      check_eq("issue_lat", 32'({store, load}), 32'h2);
      repeat (3) @(posedge clk); #1;
      check_eq("store_drop", 32'({store, load, rsp_valid}), 0);
      check_eq("count_pop", 32'(count), 0);
      @(posedge clk); #1;
      check_eq("idle_after_gap", 32'(busy), 0);

      // Single load returns the byte the SRAM holds
      push_req(1'b0, 14'h0123, 16'($urandom));
      n = 0;
      while (!rsp_valid && n < 30) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq("rsp_seen", 32'(rsp_valid), 1);
      check_eq("rsp_lat", 32'(mem_done), 1);
      check_eq("rsp_load", 32'({rsp_err, rsp_data}), 32'h0EF);
      @(posedge clk); #1;
      check_eq("rsp_pulse", 32'(rsp_valid), 0);
      check_eq("rsp_hold", 32'(rsp_data), 32'hEF);
      wait_idle(20);

      // Fill to DEPTH, then backpressure on the fifth request
      lat = 10;
      push_req(1'b1, 14'h0010, 16'h0A55);
      push_req(1'b0, 14'h0010, 16'h1111);
      push_req(1'b1, 14'h0020, 16'h1177);
      push_req(1'b0, 14'h0020, 16'h2222);
      check_eq("full_count", 32'(count), 4);
      check_eq("full_ready", 32'(req_ready), 0);
      n = 0;
      while (count == 4 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq("first_pop", 32'(count), 3);
      check_eq("ready_after_pop", 32'(req_ready), 1);
      push_req(1'b0, 14'h0123, 16'h3333);
      check_eq("refill_count", 32'(count), 4);

      // Push attempted in the same cycle as a pop at full: rejected
      n = 0;
      do begin
         @(negedge clk); #2;
         n++;
      end while (!mem_done && n < 50);
      check_eq("sim_done", 32'(mem_done), 1);
      check_eq("sim_ready", 32'(req_ready), 0);
      check_eq("sim_full", 32'(count), 4);
      req_valid = 1'b1; req_is_store = 1'b1; req_addr = 14'h3FFF; req_data = 16'hDEAD;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check_eq("sim_count", 32'(count), 3);
      wait_idle(200);
      check_eq("fill_drained", exp_iss.size(), 0);

      // Timeout on a load, then the next request completes normally
      lat = 0;
      push_req(1'b0, 14'h0200, 16'h4444);
      push_req(1'b1, 14'h0300, 16'h1234);
      n = 0;
      while (!timeout_err && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq("to_flag", 32'(timeout_err), 1);
      check_eq("to_rsp", 32'({rsp_valid, rsp_err, rsp_data}), 32'h3EF);
      lat = 2;
      push_req(1'b0, 14'h0300, 16'h5555);
      wait_idle(40);
      check_eq("after_to_load", 32'({rsp_err, rsp_data}), 32'h034);
      check_eq("to_sticky", 32'(timeout_err), 32'(exp_terr));

      // Reset in the middle of an issue with entries queued
      lat = 0;
      push_req(1'b1, 14'h0400, 16'h6666);
      push_req(1'b0, 14'h0500, 16'h7777);
      push_req(1'b1, 14'h0600, 16'h8888);
      check_eq("pre_rst_count", 32'(count), 3);
      check_eq("pre_rst_issue", 32'(store | load), 1);
      #2 reset = 1'b1;
      #1;
      check_eq("rst_async", 32'({store, load, timeout_err, rsp_valid}), 0);
      check_eq("rst_flush", 32'(count), 0);
      exp_iss.delete();
      exp_rsp.delete();
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      seen = rsp_seen;
      stray = 1'b1;
      @(negedge clk); #2;
      stray = 1'b0;
      repeat (4) @(posedge clk); #1;
      check_eq("stray_no_rsp", rsp_seen, seen);
      check_eq("stray_state", 32'({busy, req_ready}), 32'h1);
      check_eq("stray_count", 32'(count), 0);

      check_eq("iss_left", exp_iss.size(), 0);
      check_eq("rsp_left", exp_rsp.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
